phase_unwrap: RTL and testbench

PHASE_UNWRAP -- requirements
Module: phase_unwrap

---
 rtl/cordic_pkg.sv | 27 ++
 rtl/phase_wrap_diff.sv | 35 +++
 rtl/phase_unwrap.sv | 153 +++++++++++++++
 tb/tb_phase_unwrap.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants, FSM state and correction-code types for the
// CORDIC back-end (phase unwrapper and its wrap-difference helper).
package cordic_pkg;

    localparam int     AW_DEF     = 32;
    localparam int     ACC_W_DEF  = 40;
    localparam longint PI_VAL_DEF = 64'sd11796480;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        RUN   = 2'd2
    } uw_state_t;

    // CORR_DEC: d was above +pi, 2*pi removed, wrap count goes down.
    // CORR_INC: d was below -pi, 2*pi added, wrap count goes up.
    typedef enum logic [1:0] {
        CORR_NONE = 2'b00,
        CORR_DEC  = 2'b01,
        CORR_INC  = 2'b10
    } corr_t;

    function automatic longint two_pi(input longint pi);
        return 2 * pi;
    endfunction

endpackage

// File: rtl/phase_wrap_diff.sv
// Combinational sample-to-sample difference with +/-2*pi correction.
// Ports: angle, prev (AW signed) -> d (AW+1 signed), corr (corr_t).
module phase_wrap_diff
    import cordic_pkg::*;
#(
    parameter int     AW     = AW_DEF,
    parameter longint PI_VAL = PI_VAL_DEF
) (
    input  logic signed [AW-1:0] angle,
    input  logic signed [AW-1:0] prev,
    output logic signed [AW:0]   d,
    output corr_t                corr
);

    localparam logic signed [AW+1:0] PI_W     = (AW+2)'(PI_VAL);
    localparam logic        [AW:0]   TWO_PI_D = (AW+1)'(two_pi(PI_VAL));

    // Compared with one spare bit so the +/-pi tests cannot overflow;
    // the corrected result always fits in AW+1 bits.
    logic signed [AW+1:0] raw;

    always_comb begin
        raw  = {{2{angle[AW-1]}}, angle} - {{2{prev[AW-1]}}, prev};
        d    = raw[AW:0];
        corr = CORR_NONE;
        if (raw > PI_W) begin
            d    = raw[AW:0] - TWO_PI_D;
            corr = CORR_DEC;
        end else if (raw < -PI_W) begin
            d    = raw[AW:0] + TWO_PI_D;
            corr = CORR_INC;
        end
    end

endmodule

// File: rtl/phase_unwrap.sv
// Two-stage phase unwrapper: wrapped CORDIC angle in, unwrapped and
// saturating accumulated phase out, with net wrap count and sticky ovf.
// Ports: clk, rst_n (sync, active-high), clear, angle_in/angle_vld in;
// phase_out/phase_vld, wrap_cnt, ovf out. Defining PHASE_UNWRAP_DELTA_EN
// adds phase_delta, the corrected per-sample difference.
module phase_unwrap
    import cordic_pkg::*;
#(
    parameter int     AW     = AW_DEF,
    parameter int     ACC_W  = ACC_W_DEF,
    parameter longint PI_VAL = PI_VAL_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic signed [AW-1:0]    angle_in,
    input  logic                    angle_vld,
    output logic signed [ACC_W-1:0] phase_out,
    output logic                    phase_vld,
    output logic signed [15:0]      wrap_cnt,
    output logic                    ovf
`ifdef PHASE_UNWRAP_DELTA_EN
    ,
    output logic signed [AW:0]      phase_delta
`endif
);

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [15:0] WC_MAX = 16'sh7fff;
    localparam logic signed [15:0] WC_MIN = 16'sh8001;

    uw_state_t state_q;
    uw_state_t state_d;

    logic                 accept;
    logic signed [AW-1:0] prev;
    logic signed [AW:0]   d_w;
    corr_t                corr_w;

    logic                 s1_vld;
    logic                 s1_load;
    logic signed [AW:0]   s1_d;
    corr_t                s1_corr;

    logic signed [ACC_W:0]   sum;
    logic signed [ACC_W-1:0] acc_nxt;
    logic                    sat_hit;
    logic signed [15:0]      wc_nxt;

    // clear wins over a coincident sample
    assign accept = angle_vld && (state_q != IDLE) && !clear;

    phase_wrap_diff #(
        .AW     (AW),
        .PI_VAL (PI_VAL)
    ) u_diff (
        .angle (angle_in),
        .prev  (prev),
        .d     (d_w),
        .corr  (corr_w)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = FIRST;
            FIRST:   if (accept) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = IDLE;
        endcase
        if (clear) begin
            state_d = IDLE;
        end
    end

    // Stage 2 arithmetic: one guard bit detects signed overflow.
    // A first sample reuses s1_d to carry its sign-extended angle.
    always_comb begin
        sum     = {phase_out[ACC_W-1], phase_out}
                + {{(ACC_W-AW){s1_d[AW]}}, s1_d};
        acc_nxt = sum[ACC_W-1:0];
        sat_hit = 1'b0;
        if (s1_load) begin
            acc_nxt = {{(ACC_W-AW-1){s1_d[AW]}}, s1_d};
        end else if (sum[ACC_W] != sum[ACC_W-1]) begin
            sat_hit = 1'b1;
            acc_nxt = sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    always_comb begin
        wc_nxt = wrap_cnt;
        case (s1_corr)
            CORR_INC: if (wrap_cnt != WC_MAX) wc_nxt = wrap_cnt + 16'sd1;
            CORR_DEC: if (wrap_cnt != WC_MIN) wc_nxt = wrap_cnt - 16'sd1;
            default:  wc_nxt = wrap_cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n || clear) begin
            prev      <= '0;
            s1_vld    <= 1'b0;
            s1_load   <= 1'b0;
            s1_d      <= '0;
            s1_corr   <= CORR_NONE;
            phase_out <= '0;
            phase_vld <= 1'b0;
            wrap_cnt  <= '0;
            ovf       <= 1'b0;
        end else begin
            s1_vld    <= accept;
            phase_vld <= s1_vld;
            if (accept) begin
                prev <= angle_in;
                if (state_q == FIRST) begin
                    s1_load <= 1'b1;
                    s1_d    <= {angle_in[AW-1], angle_in};
                    s1_corr <= CORR_NONE;
                end else begin
                    s1_load <= 1'b0;
                    s1_d    <= d_w;
                    s1_corr <= corr_w;
                end
            end
            if (s1_vld) begin
                phase_out <= acc_nxt;
                wrap_cnt  <= wc_nxt;
                ovf       <= ovf | sat_hit;
            end
        end
    end

`ifdef PHASE_UNWRAP_DELTA_EN
    always_ff @(posedge clk) begin
        if (rst_n || clear) begin
            phase_delta <= '0;
        end else if (s1_vld) begin
            phase_delta <= s1_load ? '0 : s1_d;
        end
    end
`endif

endmodule

// File: tb/tb_phase_unwrap.sv
// Directed bench for phase_unwrap: behavioural model feeds a scoreboard
// queue per DUT, monitors pop and compare on the falling edge.
module tb_phase_unwrap;

    localparam longint DEG    = 65536;
    localparam longint S_PI   = 64'sd1073741824;
    localparam longint S_STEP = (170 * S_PI) / 180;
    localparam longint S_MAX  = 64'sd8589934591;

    typedef struct {
        bit     first;
        longint prev;
        longint acc;
        longint wc;
        bit     ovf;
        longint pi;
        longint amax;
        longint amin;
    } mdl_t;

    typedef struct {
        longint phase;
        longint wc;
        longint delta;
        bit     ovf;
        int     cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    logic               m_clear = 1'b0;
    logic signed [31:0] m_angle = '0;
    logic               m_vld = 1'b0;
    logic signed [39:0] m_phase;
    logic               m_pvld;
    logic signed [15:0] m_wc;
    logic               m_ovf;

    logic               s_clear = 1'b0;
    logic signed [31:0] s_angle = '0;
    logic               s_vld = 1'b0;
    logic signed [33:0] s_phase;
    logic               s_pvld;
    logic signed [15:0] s_wc;
    logic               s_ovf;

`ifdef PHASE_UNWRAP_DELTA_EN
    logic signed [32:0] m_delta;
    logic signed [32:0] s_delta;
`endif

    mdl_t mm;
    mdl_t sm;
    exp_t mq[$];
    exp_t sq[$];
    exp_t me;
    exp_t se;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    phase_unwrap u_main (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (m_clear),
        .angle_in  (m_angle),
        .angle_vld (m_vld),
        .phase_out (m_phase),
        .phase_vld (m_pvld),
        .wrap_cnt  (m_wc),
        .ovf       (m_ovf)
`ifdef PHASE_UNWRAP_DELTA_EN
        ,
        .phase_delta (m_delta)
`endif
    );

    phase_unwrap #(
        .AW     (32),
        .ACC_W  (34),
        .PI_VAL (S_PI)
    ) u_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (s_clear),
        .angle_in  (s_angle),
        .angle_vld (s_vld),
        .phase_out (s_phase),
        .phase_vld (s_pvld),
        .wrap_cnt  (s_wc),
        .ovf       (s_ovf)
`ifdef PHASE_UNWRAP_DELTA_EN
        ,
        .phase_delta (s_delta)
`endif
    );

    task automatic chk(input string tag, input longint obs,
                       input longint exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic mreset(inout mdl_t m, input longint pi,
                          input longint amax);
        m.first = 1'b1;
        m.prev  = 0;
        m.acc   = 0;
        m.wc    = 0;
        m.ovf   = 1'b0;
        m.pi    = pi;
        m.amax  = amax;
        m.amin  = -amax - 1;
    endtask

    task automatic mstep(inout mdl_t m, input longint a, output exp_t e);
        longint d;
        if (m.first) begin
            m.acc   = a;
            d       = 0;
            m.first = 1'b0;
        end else begin
            d = a - m.prev;
            if (d > m.pi) begin
                d = d - 2 * m.pi;
                if (m.wc > -32767) m.wc = m.wc - 1;
            end else if (d < -m.pi) begin
                d = d + 2 * m.pi;
                if (m.wc < 32767) m.wc = m.wc + 1;
            end
            m.acc = m.acc + d;
            if (m.acc > m.amax) begin
                m.acc = m.amax;
                m.ovf = 1'b1;
            end else if (m.acc < m.amin) begin
                m.acc = m.amin;
                m.ovf = 1'b1;
            end
        end
        m.prev  = a;
        e.phase = m.acc;
        e.wc    = m.wc;
        e.delta = d;
        e.ovf   = m.ovf;
        e.cyc   = 0;
    endtask

    always @(negedge clk) begin
        if (m_pvld) begin
            if (mq.size() == 0) begin
                chk("m_unexpected_vld", 1, 0);
            end else begin
                me = mq.pop_front();
                chk("m_latency", cyc, me.cyc);
                chk("m_phase", longint'(m_phase), me.phase);
                chk("m_wrap_cnt", longint'(m_wc), me.wc);
                chk("m_ovf", longint'(m_ovf), longint'(me.ovf));
`ifdef PHASE_UNWRAP_DELTA_EN
                chk("m_delta", longint'(m_delta), me.delta);
`endif
            end
        end
        if (s_pvld) begin
            if (sq.size() == 0) begin
                chk("s_unexpected_vld", 1, 0);
            end else begin
                se = sq.pop_front();
                chk("s_latency", cyc, se.cyc);
                chk("s_phase", longint'(s_phase), se.phase);
                chk("s_wrap_cnt", longint'(s_wc), se.wc);
                chk("s_ovf", longint'(s_ovf), longint'(se.ovf));
`ifdef PHASE_UNWRAP_DELTA_EN
                chk("s_delta", longint'(s_delta), se.delta);
`endif
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int deg);
        longint a;
        exp_t   e;
        a       = longint'(deg) * DEG;
        m_angle = a[31:0];
        m_vld   = 1'b1;
        mstep(mm, a, e);
        e.cyc = cyc + 2;
        mq.push_back(e);
        tick(1);
    endtask

    task automatic ssend(input longint a);
        exp_t e;
        s_angle = a[31:0];
        s_vld   = 1'b1;
        mstep(sm, a, e);
        e.cyc = cyc + 2;
        sq.push_back(e);
        tick(1);
    endtask

    task automatic idle(input int n);
        m_vld = 1'b0;
        s_vld = 1'b0;
        tick(n);
    endtask

    task automatic flush_in_flight();
        while (mq.size() > 0 && mq[$].cyc > cyc) void'(mq.pop_back());
        while (sq.size() > 0 && sq[$].cyc > cyc) void'(sq.pop_back());
    endtask

    // Clear with an optional coincident sample that must be dropped.
    task automatic mclear(input bit with_vld, input int deg);
        longint a;
        a       = longint'(deg) * DEG;
        m_angle = a[31:0];
        m_vld   = with_vld;
        m_clear = 1'b1;
        flush_in_flight();
        mreset(mm, 64'sd11796480, 64'sd549755813887);
        tick(1);
        m_clear = 1'b0;
        idle(1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((mq.size() + sq.size()) > 0 && n < 10) begin
            tick(1);
            n++;
        end
        chk("drain_queue", longint'(mq.size() + sq.size()), 0);
    endtask

    initial begin
        longint a;
        mreset(mm, 64'sd11796480, 64'sd549755813887);
        mreset(sm, S_PI, S_MAX);

        tick(3);
        chk("rst_phase", longint'(m_phase), 0);
        chk("rst_vld", longint'(m_pvld), 0);
        chk("rst_wrap_cnt", longint'(m_wc), 0);
        chk("rst_ovf", longint'(m_ovf), 0);

        // sample in IDLE right after reset release is ignored
        rst_n   = 1'b0;
        m_angle = 32'(99 * DEG);
        m_vld   = 1'b1;
        tick(1);
        send(10);
        send(20);
        idle(1);
        drain();

        mclear(1'b0, 0);
        send(170);
        send(-170);
        idle(1);
        drain();
        chk("wrap_plus_cnt", longint'(m_wc), 1);

        mclear(1'b0, 0);
        send(-170);
        send(170);
        idle(1);
        drain();
        chk("wrap_minus_phase", longint'(m_phase), -190 * DEG);

        mclear(1'b0, 0);
        send(0);
        send(90);
        send(180);
        send(-90);
        idle(1);
        drain();
        chk("b2b_final", longint'(m_phase), 270 * DEG);

        // exactly +/-pi differences stay uncorrected
        mclear(1'b0, 0);
        send(0);
        send(180);
        send(0);
        send(-180);
        idle(1);
        drain();
        chk("pi_edge_cnt", longint'(m_wc), 0);

        // clear together with a sample, one sample still in flight
        mclear(1'b0, 0);
        send(30);
        send(40);
        mclear(1'b1, 50);
        send(45);
        idle(1);
        drain();
        chk("after_clear_phase", longint'(m_phase), 45 * DEG);

        // reset mid-stream
        send(10);
        send(20);
        rst_n = 1'b1;
        m_vld = 1'b0;
        flush_in_flight();
        mreset(mm, 64'sd11796480, 64'sd549755813887);
        tick(1);
        chk("midrst_vld", longint'(m_pvld), 0);
        chk("midrst_phase", longint'(m_phase), 0);
        rst_n = 1'b0;
        idle(3);
        chk("midrst_quiet", longint'(mq.size()), 0);

        // saturation on the narrow accumulator
        a = 0;
        for (int k = 0; k <= 40; k++) begin
            ssend(a);
            a = a + S_STEP;
            if (a > S_PI) a = a - 2 * S_PI;
        end
        idle(1);
        drain();
        chk("sat_phase", longint'(s_phase), S_MAX);
        chk("sat_ovf", longint'(s_ovf), 1);
        idle(5);
        chk("sat_ovf_sticky", longint'(s_ovf), 1);
        s_clear = 1'b1;
        tick(1);
        s_clear = 1'b0;
        mreset(sm, S_PI, S_MAX);
        chk("sat_clr_ovf", longint'(s_ovf), 0);
        chk("sat_clr_phase", longint'(s_phase), 0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
